// File: rtl/adder_seq_arbiter_pkg.sv
// Shared types and default sizing for the sequential multi-word adder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_seq_pkg;

  // Controller phases: waiting for a request, stepping words, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NWORDS = 4;
  localparam int DEF_NREQ   = 2;

  localparam int OPW    = DEF_WIDTH * DEF_NWORDS;
  localparam int WIDX_W = $clog2(DEF_NWORDS);
  localparam int PTR_W  = $clog2(DEF_NREQ);

endpackage

// File: rtl/adder_seq_arbiter_if.sv
// Requester-side bundle: per-requester request/operands in, shared grant/result out.
// Latency: n/a (wires only).
// Backpressure: requester holds req and operands until done.
interface adder_seq_arbiter_if
  import adder_seq_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int OPW  = adder_seq_pkg::OPW
);
  logic [NREQ-1:0]     req;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic [NREQ-1:0]     req_cin;
  logic [NREQ-1:0]     grant;
  logic                done;
  logic [OPW-1:0]      result;
  logic                cout;
  logic                ovf;
  logic                busy;

  // Request sources drive operands and observe the shared result.
  modport master (
    output req, req_a, req_b, req_cin,
    input  grant, done, result, cout, ovf, busy
  );

  // The arbiter consumes requests and publishes the result.
  modport slave (
    input  req, req_a, req_b, req_cin,
    output grant, done, result, cout, ovf, busy
  );
endinterface

// File: rtl/adder_seq_arbiter_full_adder.sv
// Tile word adder: c/carry_out = a + b (+ carry_in when carry_listen), zero when off.
// Latency: combinational, ack follows on_off in the same cycle.
// Backpressure: none; ack is high whenever the adder is enabled.
module full_adder #(
  parameter int width = 16
) (
  input  logic             on_off,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             carry_listen,
  input  logic             carry_in,
  output logic [width-1:0] c,
  output logic             carry_out,
  output logic             ack
);
  logic [width:0] sum;

  // Widen by one bit so the carry falls out of the top; force zero when off.
  always_comb begin
    sum = '0;
    if (on_off) begin
      sum = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, (carry_listen & carry_in)};
    end
  end

  assign c         = sum[width-1:0];
  assign carry_out = sum[width];
  assign ack       = on_off;
endmodule

// File: rtl/adder_seq_arbiter.sv
// Round-robin shares one full_adder among NREQ requesters, adding NWORDS words LSW first.
// Latency: done NWORDS+1 cycles after the IDLE cycle that samples req (ack always high).
// Backpressure: adder ack low stalls the word walk; ADDSEQ_OVERFLOW_EN enables signed ovf.
module adder_seq_arbiter
  import adder_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NWORDS = DEF_NWORDS,
  parameter int NREQ   = DEF_NREQ
) (
  input  logic                 clk,
  input  logic                 reset,
  adder_seq_arbiter_if.slave   bus
);
  localparam int LOPW    = WIDTH * NWORDS;
  localparam int LWIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LPTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]         state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [LPTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LPTR_W-1:0]  gidx_q, gidx_d;
  logic [LWIDX_W-1:0] word_idx_q, word_idx_d;
  logic               carry_q, carry_d;
  logic [LOPW-1:0]    a_q, a_d;
  logic [LOPW-1:0]    b_q, b_d;
  logic               cin_q, cin_d;
  logic [LOPW-1:0]    result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_on_off;
  logic [WIDTH-1:0]   fa_a;
  logic [WIDTH-1:0]   fa_b;
  logic               fa_listen;
  logic               fa_cin;
  logic [WIDTH-1:0]   fa_c;
  logic               fa_cout;
  logic               fa_ack;

  logic [LPTR_W:0]    pick;
  logic               pick_vld;
  logic [LPTR_W-1:0]  pick_idx;

  // First set request at or above ptr, wrapping; returns {found, index}.
  function automatic logic [LPTR_W:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [LPTR_W-1:0] ptr);
    logic              found;
    logic [LPTR_W-1:0] idx;
    int                j;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = LPTR_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // Arbitration candidate for this cycle; only acted on in IDLE.
  always_comb begin
    pick     = rr_pick(bus.req, rr_ptr_q);
    pick_vld = pick[LPTR_W];
    pick_idx = pick[LPTR_W-1:0];
  end

  // Adder is only enabled in RUN; word 0 takes the requester's cin, later words the chained carry.
  always_comb begin
    fa_on_off = 1'b0;
    fa_listen = 1'b0;
    fa_a      = '0;
    fa_b      = '0;
    fa_cin    = 1'b0;
    if (state_q == S_RUN) begin
      fa_on_off = 1'b1;
      fa_listen = 1'b1;
      fa_a      = a_q[int'(word_idx_q)*WIDTH +: WIDTH];
      fa_b      = b_q[int'(word_idx_q)*WIDTH +: WIDTH];
      fa_cin    = (word_idx_q == '0) ? cin_q : carry_q;
    end
  end

  full_adder #(
    .width (WIDTH)
  ) u_fa (
    .on_off       (fa_on_off),
    .a            (fa_a),
    .b            (fa_b),
    .carry_listen (fa_listen),
    .carry_in     (fa_cin),
    .c            (fa_c),
    .carry_out    (fa_cout),
    .ack          (fa_ack)
  );

  // Controller: grant and latch in IDLE, accept one word per acked cycle in RUN, rotate in DONE.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    word_idx_d = word_idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d    = NREQ'(1) << pick_idx;
          gidx_d     = pick_idx;
          a_d        = bus.req_a[int'(pick_idx)*LOPW +: LOPW];
          b_d        = bus.req_b[int'(pick_idx)*LOPW +: LOPW];
          cin_d      = bus.req_cin[pick_idx];
          word_idx_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (fa_ack) begin
          result_d[int'(word_idx_q)*WIDTH +: WIDTH] = fa_c;
          carry_d = fa_cout;
          if (word_idx_q == LWIDX_W'(NWORDS - 1)) begin
            cout_d     = fa_cout;
`ifdef ADDSEQ_OVERFLOW_EN
            ovf_d      = (fa_a[WIDTH-1] == fa_b[WIDTH-1]) && (fa_c[WIDTH-1] != fa_a[WIDTH-1]);
`else
            ovf_d      = 1'b0;
`endif
            word_idx_d = '0;
            state_d    = S_DONE;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        rr_ptr_d = LPTR_W'((int'(gidx_q) + 1) % NREQ);
        grant_d  = '0;
        state_d  = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset discards any partial operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      word_idx_q <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      word_idx_q <= word_idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Bench for adder_seq_arbiter: transaction-level model plus directed literal cases and random traffic.
// Latency: expects done NWORDS+1 cycles after the sampling IDLE cycle.
// Backpressure: requesters hold req/operands until done.
module tb_adder_seq_arbiter;
  localparam int NW  = 4;
  localparam int NR  = 2;
  localparam int OW  = 64;
`ifdef ADDSEQ_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  adder_seq_arbiter_if #(.NREQ(NR), .OPW(OW)) ifc ();

  adder_seq_arbiter #(.WIDTH(16), .NWORDS(NW), .NREQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1..NW words in flight, NW+1 the done cycle.
  int          m_phase;
  int          m_ptr;
  int          m_g;
  logic [64:0] m_sum;
  logic        m_ovfp;
  logic [63:0] m_res;
  logic        m_cout;
  logic        m_ovf;
  bit          started;

  always @(posedge clk) begin
    logic [63:0] ma, mb;
    bit          fnd;
    int          j;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_g = 0;
      m_res = '0; m_cout = 1'b0; m_ovf = 1'b0;
      started = 1'b1;
    end else if (m_phase == 0) begin
      fnd = 1'b0;
      for (int i = 0; i < NR; i++) begin
        j = (m_ptr + i) % NR;
        if (!fnd && ifc.req[j]) begin
          fnd = 1'b1;
          m_g = j;
        end
      end
      if (fnd) begin
        ma     = ifc.req_a[m_g*OW +: OW];
        mb     = ifc.req_b[m_g*OW +: OW];
        m_sum  = {1'b0, ma} + {1'b0, mb} + 65'(ifc.req_cin[m_g]);
        m_ovfp = (ma[63] == mb[63]) && (m_sum[63] != ma[63]);
        m_phase = 1;
      end
    end else if (m_phase <= NW) begin
      m_phase++;
      if (m_phase == NW + 1) begin
        m_res  = m_sum[63:0];
        m_cout = m_sum[64];
        m_ovf  = OVF_EN ? m_ovfp : 1'b0;
      end
    end else begin
      m_phase = 0;
      m_ptr   = (m_g + 1) % NR;
    end
  end

  // Every cycle: compare visible outputs with the model.
  always @(negedge clk) begin
    logic [1:0] eg;
    if (started) begin
      eg = (m_phase != 0) ? (2'b01 << m_g) : 2'b00;
      chk("grant", 64'(ifc.grant), 64'(eg));
      chk("busy", 64'(ifc.busy), 64'(m_phase != 0));
      chk("done", 64'(ifc.done), 64'(m_phase == NW + 1));
      chk("on_off", 64'(dut.u_fa.on_off), 64'(m_phase >= 1 && m_phase <= NW));
      if (m_phase == 0 || m_phase == NW + 1) begin
        chk("result", ifc.result, m_res);
        chk("cout", 64'(ifc.cout), 64'(m_cout));
        chk("ovf", 64'(ifc.ovf), 64'(m_ovf));
      end
    end
  end

  task automatic set_ops(input int idx, input logic [63:0] a, input logic [63:0] b, input logic cin);
    ifc.req_a[idx*OW +: OW] = a;
    ifc.req_b[idx*OW +: OW] = b;
    ifc.req_cin[idx]        = cin;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.done && n < 40);
    if (!ifc.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, required within 40", n);
    end
  endtask

  // One directed operation from IDLE with literal expectations.
  task automatic do_op(input string nm, input int idx, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic [63:0] er, input logic ec);
    int n;
    @(negedge clk);
    set_ops(idx, a, b, cin);
    ifc.req = 2'b01 << idx;
    wait_done(n);
    chk({nm, "_latency"}, 64'(n), 64'(5));
    chk({nm, "_result"}, ifc.result, er);
    chk({nm, "_cout"}, 64'(ifc.cout), 64'(ec));
    chk({nm, "_grant"}, 64'(ifc.grant), 64'(2'b01 << idx));
    ifc.req = '0;
  endtask

  initial begin
    int n;
    errors = 0; checks = 0;
    reset = 1'b1;
    ifc.req = '0; ifc.req_a = '0; ifc.req_b = '0; ifc.req_cin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(ifc.grant), 64'd0);
    chk("rst_done", 64'(ifc.done), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_result", ifc.result, 64'd0);
    chk("rst_cout_ovf", 64'({ifc.cout, ifc.ovf}), 64'd0);
    chk("rst_on_off", 64'(dut.u_fa.on_off), 64'd0);
    reset = 1'b0;

    do_op("carry", 0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
    do_op("wrap", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
    do_op("cin", 0, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0);
    do_op("ovf", 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    chk("ovf_flag", 64'(ifc.ovf), 64'(OVF_EN));

    // Arbitration from a fresh reset: 0 then 1, then 0 again after the pointer wraps.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    set_ops(0, 64'h1234, 64'h1111, 1'b0);
    set_ops(1, 64'h5000, 64'h0005, 1'b1);
    ifc.req = 2'b11;
    wait_done(n);
    chk("arb_first_grant", 64'(ifc.grant), 64'h1);
    chk("arb_first_result", ifc.result, 64'h2345);
    wait_done(n);
    chk("arb_gap", 64'(n), 64'd6);
    chk("arb_second_grant", 64'(ifc.grant), 64'h2);
    chk("arb_second_result", ifc.result, 64'h5006);
    ifc.req = '0;
    @(negedge clk);
    ifc.req = 2'b11;
    wait_done(n);
    chk("arb_wrap_grant", 64'(ifc.grant), 64'h1);
    ifc.req = '0;

    // Reset while word 2 is in the adder.
    @(negedge clk);
    set_ops(0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 1'b0);
    ifc.req = 2'b01;
    repeat (3) @(negedge clk);
    chk("mid_word_idx", 64'(dut.word_idx_q), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_grant", 64'(ifc.grant), 64'd0);
    chk("mid_busy", 64'(ifc.busy), 64'd0);
    chk("mid_done", 64'(ifc.done), 64'd0);
    chk("mid_result", ifc.result, 64'd0);
    reset = 1'b0;
    ifc.req = '0;
    do_op("after_rst", 0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 1'b0,
          64'hBBBB_CCCC_DDDD_EEEE, 1'b0);

    // Random traffic, some requesters kept asserted for back-to-back service.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        set_ops(r, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      ifc.req = 2'($urandom_range(1, 3));
      wait_done(n);
      chk("rand_latency", 64'(n), 64'd5);
      if ($urandom_range(0, 1) == 1) wait_done(n);
      ifc.req = '0;
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
